writeback: RTL

//  Final pipeline stage; producer side of the register-file write port (wen/wa/wd) that decode consumes.

---
 rtl/writeback.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
//   Final pipeline stage. Accepts retiring instructions from the memory stage
//   through a valid/ready handshake and holds them in a 2-entry FIFO. The head
//   entry retires in order, at most one per cycle, when the commit sink is
//   ready. Each retirement produces one commit record and, if the instruction
//   writes a non-x0 register, one register-file write. Retired instructions
//   are counted.
//
// Optional feature (macro WB_FORWARD_EN):
//   Adds fwd_ra / fwd_hit / fwd_data. Decode can then bypass results that are
//   still buffered here and not yet written to the register file.
//
// Ports
//   clk            clock, all state on posedge
//   reset          asynchronous reset, active low
//   in_valid       memory stage offers an instruction
//   in_ready       buffer not full (depends on registered state only)
//   in_pc          pc of the offered instruction
//   in_instr       raw instruction word
//   in_regwrite    instruction writes a register
//   in_dst         destination register
//   in_result      value to write
//   commit_ready   commit sink accepts a record this cycle
//   commit_valid   head entry is presented for retirement
//   commit_pc      pc of the head entry (0 when empty)
//   commit_instr   instruction word of the head entry (0 when empty)
//   wen / wa / wd  register-file write port (wa/wd are 0 when wen is low)
//   fwd_ra         [WB_FORWARD_EN] register decode wants to read
//   fwd_hit        [WB_FORWARD_EN] a buffered entry will write fwd_ra
//   fwd_data       [WB_FORWARD_EN] result of the youngest such entry
//   retired        commits since reset, wraps silently
// -----------------------------------------------------------------------------
module writeback #(
  parameter int DEPTH = 2,   // only 2 is supported: pointers are 1 bit
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic             in_regwrite,
  input  logic [4:0]       in_dst,
  input  logic [63:0]      in_result,
  input  logic             commit_ready,
  output logic             commit_valid,
  output logic [63:0]      commit_pc,
  output logic [31:0]      commit_instr,
  output logic             wen,
  output logic [4:0]       wa,
  output logic [63:0]      wd,
`ifdef WB_FORWARD_EN
  input  logic [4:0]       fwd_ra,
  output logic             fwd_hit,
  output logic [63:0]      fwd_data,
`endif
  output logic [CNT_W-1:0] retired
);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        regwrite;
    logic [4:0]  dst;
    logic [63:0] result;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic             head_q;
  logic             tail_q;
  logic [1:0]       count_q;
  logic [CNT_W-1:0] retired_q;

  entry_t head_e;
  logic   push;
  logic   fire;

  // Full/empty come straight from the registered count, so in_ready has no
  // combinational path from commit_ready.
  assign in_ready     = (count_q != 2'(DEPTH));
  assign commit_valid = (count_q != 2'd0);
  assign push         = in_valid & in_ready;
  assign fire         = commit_valid & commit_ready;
  assign head_e       = mem_q[head_q];
  assign retired      = retired_q;

  // NOTE: the payload storage has no reset. Validity is tracked entirely by
  // count_q, and every output derived from it is gated to 0 while empty, so
  // resetting the wide data registers would add nothing but reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{pc:       in_pc,
                         instr:    in_instr,
                         regwrite: in_regwrite,
                         dst:      in_dst,
                         result:   in_result};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      retired_q <= '0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (fire) begin
        head_q    <= ~head_q;
        retired_q <= retired_q + 1'b1;
      end
      // Simultaneous push and fire leaves the occupancy unchanged.
      case ({push, fire})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    commit_pc    = '0;
    commit_instr = '0;
    wen          = 1'b0;
    wa           = '0;
    wd           = '0;
    if (commit_valid) begin
      commit_pc    = head_e.pc;
      commit_instr = head_e.instr;
    end
    // x0 writes still retire and count, they just never reach the regfile.
    if (fire && head_e.regwrite && (head_e.dst != 5'd0)) begin
      wen = 1'b1;
      wa  = head_e.dst;
      wd  = head_e.result;
    end
  end

`ifdef WB_FORWARD_EN
  // With two entries buffered the non-head slot is the younger one and wins;
  // otherwise only the head slot holds a live entry.
  entry_t young_e;
  assign young_e = mem_q[~head_q];

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_ra != 5'd0) begin
      if (count_q == 2'd2 && young_e.regwrite && young_e.dst == fwd_ra) begin
        fwd_hit  = 1'b1;
        fwd_data = young_e.result;
      end else if (commit_valid && head_e.regwrite && head_e.dst == fwd_ra) begin
        fwd_hit  = 1'b1;
        fwd_data = head_e.result;
      end
    end
  end
`endif

endmodule
